// File: rtl/hsv_convert_seq_if.sv
// rtl/hsv_convert_seq_if.sv - pixel-in / hsv-out handshake bundle for the converter
interface hsv_convert_seq_if #(
    parameter int H_W = 9,
    parameter int S_W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [15:0]    rgb;
    logic           out_valid;
    logic           out_ready;
    logic [H_W-1:0] h;
    logic [S_W-1:0] s;
    logic [7:0]     v;

    modport master (output in_valid, rgb, out_ready, input in_ready, out_valid, h, s, v);
    modport slave  (input in_valid, rgb, out_ready, output in_ready, out_valid, h, s, v);
endinterface

// File: rtl/hsv_convert_seq.sv
// rtl/hsv_convert_seq.sv - handshaked RGB565-to-HSV converter with one shared bit-serial divider
module hsv_convert_seq #(
    parameter int H_SCALE = 360,
    parameter int H_W     = 9,
    parameter int S_MAX   = 255,
    parameter int S_W     = 8
) (
    input logic              clk,
    input logic              rst_n,
    hsv_convert_seq_if.slave bus
);
    localparam logic [23:0] S_FULL  = 24'(S_MAX);
    localparam logic [23:0] H_SIXTH = 24'(H_SCALE / 6);
    localparam logic [15:0] OFF_G   = 16'(H_SCALE / 3);
    localparam logic [15:0] OFF_B   = 16'(2 * H_SCALE / 3);
    localparam logic [16:0] H_FULL  = 17'(H_SCALE);

    typedef enum logic [2:0] {IDLE, CALC, DIV_S, DIV_H, DONE} state_t;
    state_t state, state_nx;

    logic           ready_en;
    logic           calc_ph;
    logic [15:0]    rgb_q;
    logic [7:0]     mx_q, d_q, n_mag_q;
    logic           n_neg_q;
    logic [15:0]    off_q;
    logic [H_W-1:0] h_q;
    logic [S_W-1:0] s_q;
    logic [7:0]     v_q;
    logic [3:0]     cnt_q;
    logic [7:0]     rem_q, dvs_q;
    logic [15:0]    quo_q;

    logic           accept;
    logic [7:0]     r, g, b, mx, mn, n_mag;
    logic           n_neg;
    logic [15:0]    off;
    logic [8:0]     trial;
    logic           fits;
    logic [7:0]     rem_nx;
    logic [15:0]    quo_nx;
    logic [23:0]    s_dividend, h_dividend;
    logic [H_W-1:0] h_next;

    assign accept        = bus.in_valid && (state == IDLE) && ready_en;
    assign bus.in_ready  = (state == IDLE) && ready_en;
    assign bus.out_valid = (state == DONE);
    assign bus.h         = h_q;
    assign bus.s         = s_q;
    assign bus.v         = v_q;

    always_comb begin
        r     = 8'((16'(rgb_q[15:11]) * 16'd255) / 16'd31);
        g     = 8'((16'(rgb_q[10:5]) * 16'd255) / 16'd63);
        b     = 8'((16'(rgb_q[4:0]) * 16'd255) / 16'd31);
        mn    = (r < g) ? r : g;
        mx    = b;
        off   = OFF_B;
        n_neg = r < g;
        n_mag = n_neg ? (g - r) : (r - g);
        if (b < mn) mn = b;
        // Ties at the maximum resolve to r first, then g.
        if (r >= g && r >= b) begin
            mx    = r;
            off   = 16'd0;
            n_neg = g < b;
            n_mag = n_neg ? (b - g) : (g - b);
        end else if (g >= b) begin
            mx    = g;
            off   = OFF_G;
            n_neg = b < r;
            n_mag = n_neg ? (r - b) : (b - r);
        end
    end

    // Restoring step: the remainder always stays below the divisor, so 8 bits hold it.
    always_comb begin
        trial  = {rem_q, quo_q[15]};
        fits   = trial >= {1'b0, dvs_q};
        rem_nx = fits ? 8'(trial - {1'b0, dvs_q}) : trial[7:0];
        quo_nx = {quo_q[14:0], fits};
    end

    assign s_dividend = 24'(d_q) * S_FULL;
    assign h_dividend = 24'(n_mag_q) * H_SIXTH;

    always_comb begin
        if (!n_neg_q)
            h_next = H_W'(17'(off_q) + 17'(quo_nx));
        else if (quo_nx > off_q)
            h_next = H_W'(17'(off_q) + H_FULL - 17'(quo_nx));
        else
            h_next = H_W'(17'(off_q) - 17'(quo_nx));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (calc_ph) state_nx = (d_q == 8'd0) ? DONE : DIV_S;
            DIV_S:   if (cnt_q == 4'd15) state_nx = DIV_H;
            DIV_H:   if (cnt_q == 4'd15) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            calc_ph  <= 1'b0;
            rgb_q    <= '0;
            mx_q     <= '0;
            d_q      <= '0;
            n_mag_q  <= '0;
            n_neg_q  <= 1'b0;
            off_q    <= '0;
            h_q      <= '0;
            s_q      <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
            case (state)
                IDLE: if (accept) rgb_q <= bus.rgb;
                // CALC spends one cycle registering the channel terms and one dispatching on them.
                CALC: begin
                    calc_ph <= ~calc_ph;
                    if (!calc_ph) begin
                        mx_q    <= mx;
                        d_q     <= mx - mn;
                        n_mag_q <= n_mag;
                        n_neg_q <= n_neg;
                        off_q   <= off;
                        v_q     <= mx;
                    end else if (d_q == 8'd0) begin
                        h_q <= '0;
                        s_q <= '0;
                    end else begin
                        rem_q <= s_dividend[23:16];
                        quo_q <= s_dividend[15:0];
                        dvs_q <= mx_q;
                        cnt_q <= '0;
                    end
                end
                DIV_S: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        s_q   <= S_W'(quo_nx);
                        rem_q <= h_dividend[23:16];
                        quo_q <= h_dividend[15:0];
                        dvs_q <= d_q;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                    end
                end
                DIV_H: begin
                    cnt_q <= cnt_q + 4'd1;
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q == 4'd15) h_q <= h_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/hsv_convert_seq.md
# hsv_convert_seq

Sequential, handshaked RGB565-to-HSV converter for the colour-adjust path of the graphics pipeline. It sits between the sprite/pixel fetch stage and downstream colour-adjust stages (hue shift, saturation/brightness scaling). It replaces purely combinational conversion with a shared bit-serial divider, so no wide dividers are inferred. Hue full-circle and saturation full-scale are parametrised; uniform-colour pixels take a fast path.

## Interface

Parameters:
- H_SCALE, 360: hue value for a full circle. Must be a multiple of 6 and ≤ 65532.
- H_W, 9: hue output width. Must satisfy 2^H_W ≥ H_SCALE.
- S_MAX, 255: saturation full-scale value. Must be in 1..65535.
- S_W, 8: saturation output width. Must satisfy 2^S_W > S_MAX.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  rgb is valid
- in_ready  out  1  converter can accept a pixel
- rgb  in  16  RGB565 pixel: [15:11] R5, [10:5] G6, [4:0] B5
- out_valid  out  1  h/s/v valid
- out_ready  in  1  consumer accepts the result
- h  out  H_W  hue, 0..H_SCALE-1
- s  out  S_W  saturation, 0..S_MAX
- v  out  8  value, 0..255

## Operation

- Normalisation uses floor division. Denominators are constants.
  - r = R5*255/31
  - g = G6*255/63
  - b = B5*255/31
- mx = max(r,g,b); mn = min(r,g,b); d = mx − mn; v = mx.
- If d == 0: h = 0, s = 0.
- Otherwise saturation: s = floor(d*S_MAX/mx).
- Otherwise hue. Sector priority when channels tie at max is r, then g, then b.
  - max r: n = g − b, off = 0
  - max g: n = b − r, off = H_SCALE/3
  - max b: n = r − g, off = 2*H_SCALE/3
  - q = floor(|n|*(H_SCALE/6)/d)
  - h = off + sign(n)*q; if the result is negative, add H_SCALE.
  - n = 0 gives h = off, never H_SCALE.
- Divider:
  - One restoring divider, 24-bit dividend, 16 quotient bits, 1 bit per cycle.
  - Reused for s, then for h.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, register rgb and go to CALC.
  - CALC: register r/g/b, mx, mn, d, n, off and v. If d == 0, go to DONE with h = s = 0. Otherwise go to DIV_S.
  - DIV_S: 16 cycles, then latch s and go to DIV_H.
  - DIV_H: 16 cycles, then latch h and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid is ignored outside IDLE.
- h, s and v are stable whenever out_valid = 1, until the handshake completes.
- h, s and v retain their last values after the handshake.

## Timing

- Reset (rst_n low at a clock edge):
  - state = IDLE; out_valid = 0; h = s = v = 0; divider cleared.
  - in_ready = 1 from the first cycle after rst_n is sampled high.
- Reset mid-operation aborts the conversion with no output produced, whatever the state.
- Acceptance edge is cycle 0.
- Normal latency: out_valid rises after edge 34 (1 CALC + 16 DIV_S + 16 DIV_H + transition into DONE).
- Fast path (d == 0): out_valid rises after edge 2.
- Output handshake completes on the edge where out_valid && out_ready. That edge enters IDLE.
- in_ready is high the cycle after the output handshake. There is no same-cycle bypass.
- Throughput:
  - one pixel per 36 cycles (normal path), or per 4 cycles (fast path), with out_ready held high.
- out_ready held high before out_valid has no effect.

## Test plan

- Reset, then rgb=0xF800 → out_valid at cycle 34: h=0, s=255, v=255. in_ready stays 0 throughout.
- rgb=0x07E0 → h=120, s=255, v=255.
- rgb=0x001F → h=240.
- rgb=0xF81F (r,b tie; r wins; n=−255) → h=300, s=255.
- rgb=0xFC00 (r=255, g=129) → h=30, s=255, v=255.
- rgb=0xFFFF → h=0, s=0, v=255, out_valid at cycle 2.
- rgb=0x0000 → h=0, s=0, v=0, out_valid at cycle 2.
- S_MAX=100, H_SCALE=240, rgb=0xFC00 → s=100, h=20.
- Backpressure and ignored input:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - h/s/v stay constant and in_ready stays 0 throughout.
  - A new in_valid pulse during this time is ignored.
  - Raising out_ready → in_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst_n=0 during DIV_S at cycle 10.
  - Next cycle: out_valid=0, h=s=v=0, FSM in IDLE.
  - A new pixel 0x001F then converts correctly to h=240.
